// File: rtl/serial_adder.sv
// Bit-serial adder: A + B + Cin, one bit per cycle LSB first, result after WIDTH ADD cycles.
// start is only honoured in IDLE/DONE; requests during ADD are dropped, so a controller waits for done.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | ((a_i ^ b_i) & c_i);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] s_sh_d;
    logic [CW-1:0]    cnt_d;
    logic             last_bit;

    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (s_bit),
        .c_o (c_bit)
    );

    // New sum bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign s_sh_d = s_bit;
        end else begin : g_wn
            assign s_sh_d = {s_bit, s_sh_q[WIDTH-1:1]};
        end
    endgenerate

    assign cnt_d    = cnt_q + CW'(1);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        state_q <= S_ADD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ADD: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= c_bit;
                    cnt_q   <= cnt_d;
                    if (last_bit) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= c_bit;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == S_ADD);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
